// File: rtl/ad7476a_sample_averager_pkg.sv
// Shared definitions for the AD7476A sample averager: sample width and FSM states.
package ad7476a_sample_averager_pkg;

    // Width of one AD7476A conversion result; the SPI interface uses the same value.
    localparam int ADC_SAMPLE_WIDTH = 12;
    localparam int MAX_LOG2_AVG     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

endpackage

// File: rtl/ad7476a_sample_averager_rate_ticker.sv
// Reloadable down-counter producing a one-cycle tick every PERIOD enabled clocks.
module rate_ticker #(
    parameter int PERIOD = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Holding at RELOAD while disabled makes the first tick land PERIOD cycles after enable.
    always_comb begin
        tick_o = 1'b0;
        cnt_d  = cnt_q;
        if (!enable_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            tick_o = 1'b1;
            cnt_d  = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= RELOAD;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ad7476a_sample_averager.sv
// Requests AD7476A conversions at a fixed rate and boxcar-averages 2**LOG2_AVG samples per device,
// presenting rounded results on a valid/ready port with sticky late/drop flags.
module ad7476a_sample_averager
    import ad7476a_sample_averager_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 100000000,
    parameter int SAMPLE_RATE_HZ = 1000000,
    parameter int NUM_DEVICES    = 1,
    parameter int LOG2_AVG       = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  enable_i,
    output logic                                  request_o,
    input  logic [ADC_SAMPLE_WIDTH*NUM_DEVICES-1:0] sample_i,
    input  logic                                  sample_valid_i,
    output logic [ADC_SAMPLE_WIDTH*NUM_DEVICES-1:0] avg_o,
    output logic                                  avg_valid_o,
    input  logic                                  avg_ready_i,
    output logic                                  late_o,
    output logic                                  drop_o,
    input  logic                                  clear_flags_i
);

    localparam int SW     = ADC_SAMPLE_WIDTH;
    localparam int PERIOD = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
    localparam int ACC_W  = SW + LOG2_AVG;
    localparam int RND_W  = SW + 1 + LOG2_AVG;
    localparam int CNT_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [RND_W-1:0] RND_HALF = RND_W'((1 << LOG2_AVG) >> 1);

    generate
        if (SAMPLE_RATE_HZ > CLK_FREQ_HZ || PERIOD < 2 || NUM_DEVICES <= 0 ||
            LOG2_AVG < 0 || LOG2_AVG > MAX_LOG2_AVG) begin : g_bad_params
            $error("ad7476a_sample_averager: illegal parameter combination");
        end
    endgenerate

    logic tick;

    rate_ticker #(
        .PERIOD (PERIOD)
    ) u_ticker (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .tick_o   (tick)
    );

    state_t state_q, state_d;
    logic   accept, late_set, drop_set, done, last;

    // A tick in BUSY re-issues the request; a coincident sample still counts as on time.
    always_comb begin
        state_d   = state_q;
        request_o = 1'b0;
        accept    = 1'b0;
        late_set  = 1'b0;
        case (state_q)
            ST_IDLE: if (tick) state_d = ST_REQ;
            ST_REQ: begin
                request_o = 1'b1;
                state_d   = ST_BUSY;
            end
            ST_BUSY: begin
                if (sample_valid_i) begin
                    accept  = 1'b1;
                    state_d = tick ? ST_REQ : ST_IDLE;
                end else if (tick) begin
                    late_set = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last  = (cnt_q == CNT_LAST);
    assign done  = accept && last;
    assign cnt_d = !accept ? cnt_q : (last ? '0 : cnt_q + 1'b1);

    logic [NUM_DEVICES-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [SW*NUM_DEVICES-1:0]         result;

    genvar g;
    generate
        for (g = 0; g < NUM_DEVICES; g++) begin : g_acc
            logic [ACC_W-1:0] sum;
            logic [RND_W-1:0] rounded;
            // One extra bit so the rounding offset never wraps before the shift.
            assign sum     = acc_q[g] + ACC_W'(sample_i[g*SW +: SW]);
            assign rounded = ({1'b0, sum} + RND_HALF) >> LOG2_AVG;
            assign result[g*SW +: SW] = rounded[SW-1:0];
            assign acc_d[g] = !accept ? acc_q[g] : (last ? '0 : sum);
        end
    endgenerate

    logic [SW*NUM_DEVICES-1:0] avg_q, avg_d;
    logic                      valid_q, valid_d;
    logic                      late_q, late_d, drop_q, drop_d;

    // A consume and a new result in the same cycle hand over without a bubble.
    always_comb begin
        avg_d    = avg_q;
        valid_d  = valid_q;
        drop_set = 1'b0;
        if (valid_q && avg_ready_i) valid_d = 1'b0;
        if (done) begin
            if (!valid_q || avg_ready_i) begin
                avg_d   = result;
                valid_d = 1'b1;
            end else begin
                drop_set = 1'b1;
            end
        end
    end

    assign late_d = (late_q && !clear_flags_i) || late_set;
    assign drop_d = (drop_q && !clear_flags_i) || drop_set;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            late_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
            late_q  <= late_d;
            drop_q  <= drop_d;
        end
    end

    assign avg_o       = avg_q;
    assign avg_valid_o = valid_q;
    assign late_o      = late_q;
    assign drop_o      = drop_q;

endmodule

// File: tb/tb_ad7476a_sample_averager.sv
// Scoreboard bench for ad7476a_sample_averager with PERIOD=100, LOG2_AVG=2, two devices.
module tb_ad7476a_sample_averager;

    localparam int NDEV = 2;
    localparam int L    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1, en = 1'b0, sv = 1'b0, rdy = 1'b0, clr = 1'b0;
    logic        req, vld, late, drop;
    logic [23:0] smp = '0;
    logic [23:0] avg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_v, held;

    always #5 clk = ~clk;

    ad7476a_sample_averager #(
        .CLK_FREQ_HZ    (100000000),
        .SAMPLE_RATE_HZ (1000000),
        .NUM_DEVICES    (NDEV),
        .LOG2_AVG       (L)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (en),
        .request_o      (req),
        .sample_i       (smp),
        .sample_valid_i (sv),
        .avg_o          (avg),
        .avg_valid_o    (vld),
        .avg_ready_i    (rdy),
        .late_o         (late),
        .drop_o         (drop),
        .clear_flags_i  (clr)
    );

    function automatic logic [11:0] model_avg(input logic [3:0][11:0] a);
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'(a[i]);
        return 12'((s + 2) >> 2);
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; sv = 1'b0; rdy = 1'b0; clr = 1'b0; smp = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_request();
        int k = 0;
        while (req !== 1'b1 && k < 300) begin step(); k++; end
        n_checks++;
        if (req !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_request: request_o=%b after %0d cycles, required 1", req, k);
        end
    endtask

    // Waits for a request, then answers it with one sample while the FSM is BUSY.
    task automatic send_sample(input logic [11:0] d0, input logic [11:0] d1, input bit rdy_last);
        wait_request();
        step(); step(); step();
        smp = {d1, d0};
        sv  = 1'b1;
        if (rdy_last) rdy = 1'b1;
        step();
        sv  = 1'b0;
    endtask

    task automatic run_avg(input logic [3:0][11:0] a0, input logic [3:0][11:0] a1, input bit rdy_last);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back({model_avg(a1), model_avg(a0)});
            send_sample(a0[i], a1[i], rdy_last && (i == 3));
        end
    endtask

    task automatic rand_set(output logic [3:0][11:0] a);
        for (int i = 0; i < 4; i++) a[i] = 12'($urandom_range(0, 4095));
    endtask

    task automatic test_reset();
        int pulses = 0;
        do_reset();
        n_checks += 5;
        if (req !== 1'b0)   begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
        if (vld !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b want 0", vld); end
        if (avg !== 24'h0)  begin n_fail++; $display("FAIL reset_avg: got %h want 000000", avg); end
        if (late !== 1'b0)  begin n_fail++; $display("FAIL reset_late: got %b want 0", late); end
        if (drop !== 1'b0)  begin n_fail++; $display("FAIL reset_drop: got %b want 0", drop); end
        for (int k = 0; k < 150; k++) begin step(); if (req === 1'b1) pulses++; end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL disabled_no_req: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_rate();
        logic exp_r;
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            step();
            exp_r = (k % 100 == 0);
            n_checks++;
            if (req !== exp_r) begin
                n_fail++;
                $display("FAIL rate cycle %0d: request_o=%b want %b", k, req, exp_r);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_average();
        logic [3:0][11:0] a0, a1;
        do_reset();
        en = 1'b1;
        a0 = {12'h002, 12'h002, 12'h002, 12'h001};
        rand_set(a1);
        run_avg(a0, a1, 1'b0);
        exp_v = exp_q.pop_front();
        n_checks += 3;
        if (vld !== 1'b1)          begin n_fail++; $display("FAIL avg1_valid: got %b want 1", vld); end
        if (avg !== exp_v)         begin n_fail++; $display("FAIL avg1_value: got %h want %h", avg, exp_v); end
        if (avg[11:0] !== 12'h002) begin n_fail++; $display("FAIL avg1_dev0: got %h want 002", avg[11:0]); end
        rdy = 1'b1; step(); rdy = 1'b0;
        n_checks++;
        if (vld !== 1'b0) begin n_fail++; $display("FAIL avg1_consumed: valid=%b want 0", vld); end
        a0 = {4{12'hFFF}};
        rand_set(a1);
        run_avg(a0, a1, 1'b0);
        exp_v = exp_q.pop_front();
        n_checks += 2;
        if (vld !== 1'b1)  begin n_fail++; $display("FAIL avg2_valid: got %b want 1", vld); end
        if (avg !== {exp_v[23:12], 12'hFFF}) begin n_fail++; $display("FAIL avg2_value: got %h want %h", avg, {exp_v[23:12], 12'hFFF}); end
        en = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [3:0][11:0] a0, a1;
        do_reset();
        en = 1'b1;
        rand_set(a0); rand_set(a1);
        run_avg(a0, a1, 1'b0);
        held = exp_q.pop_front();
        n_checks += 2;
        if (vld !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b want 1", vld); end
        if (avg !== held) begin n_fail++; $display("FAIL bp_first_value: got %h want %h", avg, held); end
        a0 = {4{12'h123}}; a1 = {4{12'h456}};
        run_avg(a0, a1, 1'b0);
        void'(exp_q.pop_front());
        n_checks += 3;
        if (avg !== held)  begin n_fail++; $display("FAIL bp_held: got %h want %h", avg, held); end
        if (drop !== 1'b1) begin n_fail++; $display("FAIL bp_drop: got %b want 1", drop); end
        if (vld !== 1'b1)  begin n_fail++; $display("FAIL bp_still_valid: got %b want 1", vld); end
        rand_set(a0); rand_set(a1);
        run_avg(a0, a1, 1'b1);
        exp_v = exp_q.pop_front();
        n_checks += 2;
        if (vld !== 1'b1)  begin n_fail++; $display("FAIL bp_swap_valid: got %b want 1", vld); end
        if (avg !== exp_v) begin n_fail++; $display("FAIL bp_swap_value: got %h want %h", avg, exp_v); end
        step();
        rdy = 1'b0;
        n_checks++;
        if (vld !== 1'b0) begin n_fail++; $display("FAIL bp_final_consume: valid=%b want 0", vld); end
        en = 1'b0;
    endtask

    task automatic test_late();
        do_reset();
        en = 1'b1;
        wait_request();
        // Sample arrives in the very cycle of the next tick: on time, request re-issued.
        repeat (99) step();
        smp = 24'h00A00A; sv = 1'b1;
        step();
        sv = 1'b0;
        n_checks += 2;
        if (req !== 1'b1)  begin n_fail++; $display("FAIL coincident_req: got %b want 1", req); end
        if (late !== 1'b0) begin n_fail++; $display("FAIL coincident_late: got %b want 0", late); end
        repeat (99) step();
        n_checks++;
        if (late !== 1'b0) begin n_fail++; $display("FAIL late_early: got %b want 0", late); end
        step();
        n_checks += 3;
        if (req !== 1'b1)  begin n_fail++; $display("FAIL late_rereq: got %b want 1", req); end
        if (late !== 1'b1) begin n_fail++; $display("FAIL late_set: got %b want 1", late); end
        if (drop !== 1'b0) begin n_fail++; $display("FAIL late_drop: got %b want 0", drop); end
        send_sample(12'h111, 12'h222, 1'b0);
        clr = 1'b1; step(); clr = 1'b0;
        n_checks++;
        if (late !== 1'b0) begin n_fail++; $display("FAIL late_clear: got %b want 0", late); end
        wait_request();
        clr = 1'b1;
        repeat (100) step();
        n_checks++;
        if (late !== 1'b1) begin n_fail++; $display("FAIL late_set_over_clear: got %b want 1", late); end
        step();
        clr = 1'b0;
        n_checks++;
        if (late !== 1'b0) begin n_fail++; $display("FAIL late_clear_after: got %b want 0", late); end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0][11:0] a0, a1;
        do_reset();
        en = 1'b1;
        run_avg({4{12'h800}}, {4{12'h700}}, 1'b0);
        void'(exp_q.pop_front());
        send_sample(12'h800, 12'h700, 1'b0);
        send_sample(12'h800, 12'h700, 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        n_checks += 2;
        if (vld !== 1'b0)  begin n_fail++; $display("FAIL midreset_valid: got %b want 0", vld); end
        if (avg !== 24'h0) begin n_fail++; $display("FAIL midreset_avg: got %h want 000000", avg); end
        a0 = {4{12'h010}}; a1 = {12'h004, 12'h003, 12'h002, 12'h001};
        send_sample(a0[0], a1[0], 1'b0);
        send_sample(a0[1], a1[1], 1'b0);
        n_checks++;
        if (vld !== 1'b0) begin n_fail++; $display("FAIL midreset_count: valid=%b after 2 fresh samples want 0", vld); end
        exp_q.push_back({model_avg(a1), model_avg(a0)});
        send_sample(a0[2], a1[2], 1'b0);
        send_sample(a0[3], a1[3], 1'b0);
        exp_v = exp_q.pop_front();
        n_checks += 2;
        if (vld !== 1'b1)  begin n_fail++; $display("FAIL midreset_fresh_valid: got %b want 1", vld); end
        if (avg !== exp_v) begin n_fail++; $display("FAIL midreset_fresh_value: got %h want %h", avg, exp_v); end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0][11:0] a0, a1;
        do_reset();
        en = 1'b1;
        rdy = 1'b1;
        run_avg({4{12'h100}}, {4{12'hABC}}, 1'b0);
        exp_v = exp_q.pop_front();
        n_checks += 3;
        if (vld !== 1'b1)      begin n_fail++; $display("FAIL dual_valid: got %b want 1", vld); end
        if (avg !== exp_v)     begin n_fail++; $display("FAIL dual_model: got %h want %h", avg, exp_v); end
        if (avg !== 24'hABC100) begin n_fail++; $display("FAIL dual_value: got %h want abc100", avg); end
        step();
        n_checks++;
        if (vld !== 1'b0) begin n_fail++; $display("FAIL dual_consumed: valid=%b want 0", vld); end
        rand_set(a0); rand_set(a1);
        run_avg(a0, a1, 1'b0);
        exp_v = exp_q.pop_front();
        n_checks += 2;
        if (vld !== 1'b1)  begin n_fail++; $display("FAIL b2b_valid: got %b want 1", vld); end
        if (avg !== exp_v) begin n_fail++; $display("FAIL b2b_value: got %h want %h", avg, exp_v); end
        rdy = 1'b0;
        en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: %0d entries want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_rate();
        test_average();
        test_backpressure();
        test_late();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
